// File: rtl/input_cond_pkg.sv
// Shared types for the input conditioner: per-channel edge mode encoding
// and the helper that says which modes take part in hold-to-repeat.
package input_cond_pkg;

    typedef enum logic [1:0] {
        EDGE_LEVEL = 2'b00,
        EDGE_RISE  = 2'b01,
        EDGE_FALL  = 2'b10,
        EDGE_BOTH  = 2'b11
    } edge_mode_e;

    function automatic logic repeat_capable(input edge_mode_e m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioner channel: synchroniser chain, debouncer, edge detector and
// hold-to-repeat generator feeding a single event output.
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       raw,
    input  logic [1:0] mode,
    input  logic       repeat_en,
    output logic       level,
    output logic       evt
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_V  = RCW'(REPEAT_DELAY);
    localparam logic [RCW-1:0] PERIOD_V = RCW'(REPEAT_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q;
    logic                   prev_q;
    logic [DBW-1:0]         db_cnt;
    logic [RCW-1:0]         rcnt;
    logic                   rep_phase;
    edge_mode_e             mode_e;
    logic                   rise;
    logic                   fall;
    logic                   rep_run;
    logic                   rep_hit;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = stable_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // A new level is accepted only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            prev_q <= stable_q;
            if (synced == stable_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable_q <= synced;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    // rcnt counts cycles of the current repeat run; rep_phase marks that the
    // initial delay has elapsed so later pulses use the shorter period.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (!rep_run) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (rep_hit) begin
            rcnt      <= RCW'(1);
            rep_phase <= 1'b1;
        end else begin
            rcnt <= rcnt + RCW'(1);
        end
    end

    always_comb begin
        mode_e  = edge_mode_e'(mode);
        rise    = stable_q & ~prev_q;
        fall    = ~stable_q & prev_q;
        rep_run = stable_q & repeat_en & repeat_capable(mode_e);
        rep_hit = rep_phase ? (rcnt == PERIOD_V) : (rcnt == DELAY_V);
        evt     = 1'b0;
        case (mode_e)
            EDGE_LEVEL: evt = stable_q;
            EDGE_RISE:  evt = rise;
            EDGE_FALL:  evt = fall;
            EDGE_BOTH:  evt = rise | fall;
            default:    evt = 1'b0;
        endcase
        evt = evt | (rep_run & rep_hit);
    end

endmodule

// File: rtl/input_conditioner.sv
// N-channel game-control front end: one conditioner per raw input plus an
// OR-reduced "something happened" flag for the game FSM.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int NCH           = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [NCH-1:0]   raw_i,
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   repeat_en_i,
    output logic [NCH-1:0]   level_o,
    output logic [NCH-1:0]   event_o,
    output logic             any_event_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        input_cond_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .nRst     (nRst),
            .raw      (raw_i[k]),
            .mode     (mode_i[2*k +: 2]),
            .repeat_en(repeat_en_i[k]),
            .level    (level_o[k]),
            .evt      (event_o[k])
        );
    end

    assign any_event_o = |event_o;

endmodule
